// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults and the stage-0 decode bundle.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Stage-0 decode of the scan position, consumed by the output register stage.
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       active;
        logic       hs_n;
        logic       vs_n;
        logic       frame_first;
        logic       vblank_first;
    } sync_t;

endpackage

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical scan counters with combinational sync, active and marker decode.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    output sync_t o_sync
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    // Next scan position: h steps every clock, v steps when h wraps.
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    // Counter registers, cleared by synchronous reset so a new frame starts at (0,0).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Stage-0 decode of the current position.
    always_comb begin
        o_sync              = '0;
        o_sync.active       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        o_sync.hs_n         = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
        o_sync.vs_n         = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
        o_sync.frame_first  = (h_cnt_q == '0) && (v_cnt_q == '0);
        o_sync.vblank_first = (h_cnt_q == '0) && (v_cnt_q == V_ACT);
        if (o_sync.active) begin
            o_sync.x = h_cnt_q;
            o_sync.y = v_cnt_q[8:0];
        end
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: requests pixels by (o_x,o_y) and drives a DAC one clock later.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    input  logic [23:0] i_rgb,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_vga_hs,
    output logic        o_vga_vs,
    output logic        o_vga_blank_n,
    output logic        o_vga_sync_n,
    output logic        o_frame_start,
    output logic        o_vblank_start,
    output logic [7:0]  o_frame_cnt
);

    sync_t s0;

    vga_sync_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_sync  (s0)
    );

    assign o_x = s0.x;
    assign o_y = s0.y;

    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic        frame_start_q, frame_start_d;
    logic        vblank_start_q, vblank_start_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    // Output stage inputs: colour gated by active area, frame count steps with the frame pulse.
    always_comb begin
        rgb_d          = s0.active ? i_rgb : '0;
        hs_d           = s0.hs_n;
        vs_d           = s0.vs_n;
        blank_n_d      = s0.active;
        frame_start_d  = s0.frame_first;
        vblank_start_d = s0.vblank_first;
        frame_cnt_d    = frame_cnt_q + (s0.frame_first ? 8'd1 : 8'd0);
    end

    // Single output register stage so colour, syncs, blank and pulses stay aligned.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rgb_q          <= '0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            blank_n_q      <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            rgb_q          <= rgb_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            blank_n_q      <= blank_n_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign o_vga_r        = rgb_q[23:16];
    assign o_vga_g        = rgb_q[15:8];
    assign o_vga_b        = rgb_q[7:0];
    assign o_vga_hs       = hs_q;
    assign o_vga_vs       = vs_q;
    assign o_vga_blank_n  = blank_n_q;
    assign o_vga_sync_n   = 1'b0;
    assign o_frame_start  = frame_start_q;
    assign o_vblank_start = vblank_start_q;
    assign o_frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a shrunken-timing instance exercised over 257+ frames and
// a default-timing instance for horizontal timing, both against an arithmetic scan model.
module tb_vga_scan_ctrl;

    // Shrunken timing so whole frames fit in a short run.
    localparam int unsigned HA = 8, HF = 1, HS = 2, HB = 1;
    localparam int unsigned VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
        logic        vb;
        logic [7:0]  fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] mask = '0;

    always #5 clk = ~clk;

    logic [9:0]  s_x, d_x;
    logic [8:0]  s_y, d_y;
    logic [23:0] s_rgb_in, d_rgb_in;
    logic [7:0]  s_r, s_g, s_b, d_r, d_g, d_b;
    logic        s_hs, s_vs, s_bl, s_sn, s_fs, s_vb;
    logic        d_hs, d_vs, d_bl, d_sn, d_fs, d_vb;
    logic [7:0]  s_fc, d_fc;

    assign s_rgb_in = {s_x[7:0], s_y[7:0], 8'hA5} ^ mask;
    assign d_rgb_in = {d_x[7:0], d_y[7:0], 8'hA5};

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_x(s_x), .o_y(s_y), .i_rgb(s_rgb_in),
        .o_vga_r(s_r), .o_vga_g(s_g), .o_vga_b(s_b), .o_vga_hs(s_hs), .o_vga_vs(s_vs),
        .o_vga_blank_n(s_bl), .o_vga_sync_n(s_sn), .o_frame_start(s_fs),
        .o_vblank_start(s_vb), .o_frame_cnt(s_fc)
    );

    vga_scan_ctrl dut_def (
        .i_clk(clk), .i_rst_n(rst_n), .o_x(d_x), .o_y(d_y), .i_rgb(d_rgb_in),
        .o_vga_r(d_r), .o_vga_g(d_g), .o_vga_b(d_b), .o_vga_hs(d_hs), .o_vga_vs(d_vs),
        .o_vga_blank_n(d_bl), .o_vga_sync_n(d_sn), .o_frame_start(d_fs),
        .o_vblank_start(d_vb), .o_frame_cnt(d_fc)
    );

    int          tests = 0;
    int          fails = 0;
    int unsigned t = 0;
    bit          valid = 1'b0;

    // Edge/interval trackers.
    int unsigned dfall_t = 0, sfall_t = 0, fs_t = 0;
    bit          have_dfall = 1'b0, have_sfall = 1'b0, have_fs = 1'b0;
    logic        d_hs_prev = 1'b1, s_vs_prev = 1'b1;
    logic [7:0]  fc_prev = '0;
    int          wraps = 0;

    // Expected outputs when the scan has been running for t clocks since reset release.
    function automatic exp_t model(input int unsigned tt, input bit vld,
                                   input int unsigned ha, input int unsigned hf,
                                   input int unsigned hs, input int unsigned hb,
                                   input int unsigned va, input int unsigned vf,
                                   input int unsigned vs, input int unsigned vb,
                                   input logic [23:0] m);
        int unsigned ht, vt, ft, h, v, s, ph, pv;
        bit          act;
        logic [7:0]  xb, yb;
        exp_t        e;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        ft = ht * vt;
        h  = tt % ht;
        v  = (tt / ht) % vt;
        e  = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (h < ha && v < va) begin
            e.x = 10'(h);
            e.y = 9'(v);
        end
        if (vld) begin
            s   = tt - 1;
            ph  = s % ht;
            pv  = (s / ht) % vt;
            act = (ph < ha) && (pv < va);
            xb  = 8'(ph);
            yb  = 8'(pv);
            e.rgb = act ? ({xb, yb, 8'hA5} ^ m) : 24'h0;
            e.hs  = !(ph >= ha + hf && ph < ha + hf + hs);
            e.vs  = !(pv >= va + vf && pv < va + vf + vs);
            e.bl  = act;
            e.fs  = (ph == 0) && (pv == 0);
            e.vb  = (ph == 0) && (pv == va);
            e.fc  = 8'((s / ft + 1) % 256);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, expv, t);
        end
    endtask

    // One clock: advance the model, compare both instances, update trackers, new stimulus.
    task automatic step();
        exp_t es, ed;
        @(negedge clk);
        if (!rst_n) begin
            t = 0;
            valid = 1'b0;
            have_dfall = 1'b0; have_sfall = 1'b0; have_fs = 1'b0;
            fc_prev = '0;
        end else begin
            t++;
            valid = 1'b1;
        end
        es = model(t, valid, HA, HF, HS, HB, VA, VF, VS, VB, mask);
        ed = model(t, valid, 640, 16, 96, 48, 480, 10, 2, 33, 24'h0);

        chk("s_x", 32'(s_x), 32'(es.x));
        chk("s_y", 32'(s_y), 32'(es.y));
        chk("s_rgb", 32'({s_r, s_g, s_b}), 32'(es.rgb));
        chk("s_hs", 32'(s_hs), 32'(es.hs));
        chk("s_vs", 32'(s_vs), 32'(es.vs));
        chk("s_blank_n", 32'(s_bl), 32'(es.bl));
        chk("s_sync_n", 32'(s_sn), 32'h0);
        chk("s_frame_start", 32'(s_fs), 32'(es.fs));
        chk("s_vblank_start", 32'(s_vb), 32'(es.vb));
        chk("s_frame_cnt", 32'(s_fc), 32'(es.fc));

        chk("d_x", 32'(d_x), 32'(ed.x));
        chk("d_y", 32'(d_y), 32'(ed.y));
        chk("d_rgb", 32'({d_r, d_g, d_b}), 32'(ed.rgb));
        chk("d_hs", 32'(d_hs), 32'(ed.hs));
        chk("d_vs", 32'(d_vs), 32'(ed.vs));
        chk("d_blank_n", 32'(d_bl), 32'(ed.bl));
        chk("d_sync_n", 32'(d_sn), 32'h0);
        chk("d_frame_start", 32'(d_fs), 32'(ed.fs));
        chk("d_vblank_start", 32'(d_vb), 32'(ed.vb));
        chk("d_frame_cnt", 32'(d_fc), 32'(ed.fc));

        // Last active pixel of the frame and the first blanked one right after it.
        if (valid && ((t - 1) % FT) == (VA - 1) * HT + HA - 1) begin
            chk("last_px_rgb", 32'({s_r, s_g, s_b}), 32'({8'(HA - 1), 8'(VA - 1), 8'hA5} ^ mask));
            chk("last_px_blank_n", 32'(s_bl), 32'h1);
        end
        if (valid && ((t - 1) % FT) == (VA - 1) * HT + HA) begin
            chk("past_last_px_rgb", 32'({s_r, s_g, s_b}), 32'h0);
            chk("past_last_px_blank_n", 32'(s_bl), 32'h0);
        end

        if (rst_n) begin
            // Default-timing hsync: 800-clock period, 96 low, falling after column 656.
            if (d_hs_prev && !d_hs) begin
                if (have_dfall) chk("d_hs_period", dfall_t == 0 ? 32'h0 : 32'(t - dfall_t), 32'd800);
                chk("d_hs_fall_col", 32'((t - 1) % 800), 32'd656);
                dfall_t = t;
                have_dfall = 1'b1;
            end
            if (!d_hs_prev && d_hs && have_dfall) chk("d_hs_low", 32'(t - dfall_t), 32'd96);
            // Shrunken vsync: one frame period, VS lines low.
            if (s_vs_prev && !s_vs) begin
                if (have_sfall) chk("s_vs_period", 32'(t - sfall_t), 32'(FT));
                sfall_t = t;
                have_sfall = 1'b1;
            end
            if (!s_vs_prev && s_vs && have_sfall) chk("s_vs_low", 32'(t - sfall_t), 32'(VS * HT));
            // Frame pulse spacing, frame counter stepping and vblank offset.
            if (s_fs) begin
                if (have_fs) chk("fs_period", 32'(t - fs_t), 32'(FT));
                chk("fcnt_step", 32'(s_fc), 32'(8'(fc_prev + 8'd1)));
                if (fc_prev == 8'd255 && s_fc == 8'd0) wraps++;
                fc_prev = s_fc;
                fs_t = t;
                have_fs = 1'b1;
            end
            if (s_vb && have_fs) chk("vblank_delay", 32'(t - fs_t), 32'(VA * HT));
        end
        d_hs_prev = d_hs;
        s_vs_prev = s_vs;

        mask = 24'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_hs", 32'(s_hs), 32'h1);
        chk("rst_blank_n", 32'(s_bl), 32'h0);
        chk("rst_frame_cnt", 32'(s_fc), 32'h0);
        rst_n = 1'b1;

        // 257 frames: counter walks 0..255 and wraps to 0, then to 1.
        repeat (257 * FT + 20) step();
        chk("fcnt_wraps", 32'(wraps), 32'd1);

        // Reset in mid-frame at column 5, row 2.
        for (int i = 0; i < int'(FT) && (t % FT) != 2 * HT + 5; i++) step();
        chk("mid_pos", 32'(t % FT), 32'(2 * HT + 5));
        rst_n = 1'b0;
        step();
        chk("mid_rst_hs", 32'(s_hs), 32'h1);
        chk("mid_rst_vs", 32'(s_vs), 32'h1);
        chk("mid_rst_blank_n", 32'(s_bl), 32'h0);
        chk("mid_rst_rgb", 32'({s_r, s_g, s_b}), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("resume_fs", 32'(s_fs), 32'h1);
        chk("resume_fcnt", 32'(s_fc), 32'h1);
        repeat (2 * FT + 10) step();

        // Reset at a random point, then resume.
        repeat ($urandom_range(1, 3 * FT)) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2 * FT) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
